// File: rtl/gpu_bank_arbiter.sv
// Per-bank round-robin arbiter between NUM_REQ requesters and the register banks of one warp.
// Grant is combinational, bank command one cycle after grant, read data two cycles after; losers simply hold their request.
module gpu_bank_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int NUM_BANKS     = 4,
   parameter int REGS_PER_BANK = 8,
   parameter int DATA_W        = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ*5-1:0]        req_reg,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_BANKS-1:0]        bank_read,
   output logic [NUM_BANKS-1:0]        bank_write,
   output logic [NUM_BANKS*3-1:0]      bank_target,
   output logic [NUM_BANKS*DATA_W-1:0] bank_wdata,
   input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [NUM_REQ*DATA_W-1:0]   rsp_data,
   output logic [15:0]                 conflict_cnt
);

   localparam int ID_W   = $clog2(NUM_REQ);
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int ENT_W  = $clog2(REGS_PER_BANK);
   localparam int CNT_W  = $clog2(NUM_REQ + 1);

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
      logic            rd;
   } tag_t;

   function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   logic [ID_W-1:0]   r_ptr         [NUM_BANKS];
   tag_t              r_tag1        [NUM_BANKS];
   tag_t              r_tag2        [NUM_BANKS];
   logic [NUM_BANKS-1:0] r_bank_read;
   logic [NUM_BANKS-1:0] r_bank_write;
   logic [ENT_W-1:0]  r_bank_target [NUM_BANKS];
   logic [DATA_W-1:0] r_bank_wdata  [NUM_BANKS];
   logic [15:0]       r_cnt;

   logic [BANK_W-1:0] w_req_bank  [NUM_REQ];
   logic [ENT_W-1:0]  w_req_ent   [NUM_REQ];
   logic [DATA_W-1:0] w_req_wdata [NUM_REQ];
   logic [ID_W-1:0]   w_win       [NUM_BANKS];
   logic [NUM_BANKS-1:0] w_bank_hit;
   logic [NUM_REQ-1:0]   w_gnt;
   logic [ID_W-1:0]   w_idx;
   logic [CNT_W-1:0]  w_nvld;
   logic [CNT_W-1:0]  w_ngnt;
   logic [16:0]       w_cnt_sum;
   logic [15:0]       w_cnt_next;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_req_bank[i]  = req_reg[i*5 +: BANK_W];
         w_req_ent[i]   = req_reg[i*5+BANK_W +: ENT_W];
         w_req_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
      end
   end

   // Scan upward from each bank's pointer; the first matching requester wins that bank.
   always_comb begin
      w_gnt      = '0;
      w_bank_hit = '0;
      w_idx      = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         w_win[b] = '0;
         for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = rr_idx(r_ptr[b], k);
            if (!w_bank_hit[b] && req_valid[w_idx] && (w_req_bank[w_idx] == BANK_W'(b))) begin
               w_bank_hit[b] = 1'b1;
               w_win[b]      = w_idx;
            end
         end
         if (w_bank_hit[b]) w_gnt[w_win[b]] = 1'b1;
      end
   end

   assign gnt = rst_n ? w_gnt : '0;

   // Every grant also consumes its valid, so (valid - grant) never goes negative.
   always_comb begin
      w_nvld = '0;
      w_ngnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_nvld = w_nvld + CNT_W'(req_valid[i]);
         w_ngnt = w_ngnt + CNT_W'(w_gnt[i]);
      end
      w_cnt_sum  = {1'b0, r_cnt} + 17'(w_nvld) - 17'(w_ngnt);
      w_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            r_ptr[b]         <= '0;
            r_tag1[b]        <= '0;
            r_tag2[b]        <= '0;
            r_bank_target[b] <= '0;
            r_bank_wdata[b]  <= '0;
         end
         r_bank_read  <= '0;
         r_bank_write <= '0;
         r_cnt        <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            r_tag2[b]       <= r_tag1[b];
            r_tag1[b].vld   <= w_bank_hit[b];
            r_tag1[b].id    <= w_win[b];
            r_tag1[b].rd    <= ~req_write[w_win[b]];
            r_bank_read[b]  <= w_bank_hit[b] & ~req_write[w_win[b]];
            r_bank_write[b] <= w_bank_hit[b] & req_write[w_win[b]];
            if (w_bank_hit[b]) begin
               r_ptr[b]         <= rr_idx(w_win[b], 1);
               r_bank_target[b] <= w_req_ent[w_win[b]];
               r_bank_wdata[b]  <= w_req_wdata[w_win[b]];
            end
         end
         r_cnt <= w_cnt_next;
      end
   end

   assign bank_read    = r_bank_read;
   assign bank_write   = r_bank_write;
   assign conflict_cnt = r_cnt;

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_target[b*ENT_W +: ENT_W]  = r_bank_target[b];
         bank_wdata[b*DATA_W +: DATA_W] = r_bank_wdata[b];
      end
   end

   // A requester holds at most one grant per cycle, so at most one bank steers each response lane.
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (r_tag2[b].vld && r_tag2[b].rd) begin
            rsp_valid[r_tag2[b].id] = 1'b1;
            rsp_data[int'(r_tag2[b].id)*DATA_W +: DATA_W] = bank_rdata[b*DATA_W +: DATA_W];
         end
      end
   end

   a_gnt_valid: assert property (@(posedge clk) disable iff (!rst_n) (gnt & ~req_valid) == '0);

endmodule

// File: tb/tb_gpu_bank_arbiter.sv
// Bench for gpu_bank_arbiter: vector table plus reset and saturation sequences,
// a behavioural bank memory, and a queue of expected read responses.
module tb_gpu_bank_arbiter;
   localparam int NR = 4;
   localparam int NB = 4;
   localparam int DW = 64;

   typedef struct packed {
      logic [NR-1:0]         vld;
      logic [NR-1:0]         wr;
      logic [NR-1:0][4:0]    rg;
      logic [NR-1:0][DW-1:0] wd;
      logic [NR-1:0]         exp_gnt;
   } vec_t;

   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
   } rsp_t;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_write;
   logic [NR*5-1:0]   req_reg;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     gnt;
   logic [NB-1:0]     bank_read;
   logic [NB-1:0]     bank_write;
   logic [NB*3-1:0]   bank_target;
   logic [NB*DW-1:0]  bank_wdata;
   logic [NB*DW-1:0]  bank_rdata;
   logic [NR-1:0]     rsp_valid;
   logic [NR*DW-1:0]  rsp_data;
   logic [15:0]       conflict_cnt;

   gpu_bank_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_reg(req_reg), .req_wdata(req_wdata),
      .gnt(gnt),
      .bank_read(bank_read), .bank_write(bank_write), .bank_target(bank_target),
      .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .conflict_cnt(conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int r);
      if (r == 5) return 64'hDEAD;
      return 64'hC0DE_0000_0000_0000 | 64'(r);
   endfunction

   // Bank memory: writes commit at the end of the strobe cycle, read data appears the cycle after.
   logic [DW-1:0] mem [NB][8];
   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (!rst_n) begin
            for (int e = 0; e < 8; e++) mem[b][e] <= init_val(e*4 + b);
            bank_rdata[b*DW +: DW] <= '0;
         end else begin
            if (bank_write[b]) mem[b][bank_target[b*3 +: 3]] <= bank_wdata[b*DW +: DW];
            if (bank_read[b])  bank_rdata[b*DW +: DW] <= mem[b][bank_target[b*3 +: 3]];
         end
      end
   end

   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   int            exp_cnt  = 0;
   rsp_t          sb [$];
   logic [DW-1:0] shadow  [32];
   logic [2:0]    exp_tgt [NB];
   logic [DW-1:0] exp_wd  [NB];
   logic [NB-1:0] pend_rd;
   logic [NB-1:0] pend_wr;
   vec_t          tbl [$];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [NR-1:0] vld, input logic [NR-1:0] wr,
                               input logic [NR*5-1:0] rg, input logic [NR*DW-1:0] wd,
                               input logic [NR-1:0] g);
      vec_t v;
      v.vld = vld; v.wr = wr; v.rg = rg; v.wd = wd; v.exp_gnt = g;
      return v;
   endfunction

   task automatic reset_model();
      for (int r = 0; r < 32; r++) shadow[r] = init_val(r);
      for (int b = 0; b < NB; b++) begin
         exp_tgt[b] = '0;
         exp_wd[b]  = '0;
      end
      pend_rd = '0;
      pend_wr = '0;
      exp_cnt = 0;
      sb.delete();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_write = '0;
      req_reg   = {5'd3, 5'd2, 5'd1, 5'd0};
      req_wdata = '0;
      #1;
      check("reset.gnt", {252'b0, gnt}, 256'h0);
      repeat (2) @(posedge clk);
      #1;
      check("reset.bank_read", {252'b0, bank_read}, 256'h0);
      check("reset.bank_write", {252'b0, bank_write}, 256'h0);
      check("reset.rsp_valid", {252'b0, rsp_valid}, 256'h0);
      check("reset.conflict_cnt", {240'b0, conflict_cnt}, 256'h0);
      check("reset.bank_target", {244'b0, bank_target}, 256'h0);
      check("reset.bank_wdata", bank_wdata, 256'h0);
      req_valid = '0;
      rst_n     = 1'b1;
      reset_model();
   endtask

   task automatic check_rsp(input string tag);
      logic [NR-1:0] m;
      rsp_t          r;
      m = '0;
      while (sb.size() > 0 && sb[0].due == cyc) begin
         r = sb.pop_front();
         m[r.id] = 1'b1;
         check({tag, ".rsp_data"}, {192'b0, rsp_data[r.id*DW +: DW]}, {192'b0, r.data});
      end
      check({tag, ".rsp_valid"}, {252'b0, rsp_valid}, {252'b0, m});
   endtask

   task automatic apply(input vec_t v, input string tag);
      logic [NB*3-1:0]  et;
      logic [NB*DW-1:0] ew;
      rsp_t             r;
      req_valid = v.vld;
      req_write = v.wr;
      req_reg   = v.rg;
      req_wdata = v.wd;
      #1;
      check({tag, ".gnt"}, {252'b0, gnt}, {252'b0, v.exp_gnt});
      pend_rd = '0;
      pend_wr = '0;
      for (int i = 0; i < NR; i++) begin
         if (v.exp_gnt[i]) begin
            int b;
            b = int'(v.rg[i][1:0]);
            exp_tgt[b] = v.rg[i][4:2];
            exp_wd[b]  = v.wd[i];
            if (v.wr[i]) begin
               pend_wr[b]        = 1'b1;
               shadow[v.rg[i]]   = v.wd[i];
            end else begin
               pend_rd[b] = 1'b1;
               r.due  = cyc + 2;
               r.id   = i;
               r.data = shadow[v.rg[i]];
               sb.push_back(r);
            end
         end
      end
      exp_cnt = exp_cnt + $countones(v.vld) - $countones(v.exp_gnt);
      if (exp_cnt > 65535) exp_cnt = 65535;
      @(posedge clk);
      #1;
      cyc++;
      for (int b = 0; b < NB; b++) begin
         et[b*3 +: 3]   = exp_tgt[b];
         ew[b*DW +: DW] = exp_wd[b];
      end
      check({tag, ".bank_read"}, {252'b0, bank_read}, {252'b0, pend_rd});
      check({tag, ".bank_write"}, {252'b0, bank_write}, {252'b0, pend_wr});
      check({tag, ".bank_target"}, {244'b0, bank_target}, {244'b0, et});
      check({tag, ".bank_wdata"}, bank_wdata, ew);
      check({tag, ".conflict_cnt"}, {240'b0, conflict_cnt}, {240'b0, 16'(exp_cnt)});
      check_rsp(tag);
   endtask

   initial begin
      int   sat;
      vec_t idle;
      idle = mk('0, '0, '0, '0, '0);

      tbl.push_back(mk(4'b0001, '0, {5'd0, 5'd0, 5'd0, 5'd5}, '0, 4'b0001));
      tbl.push_back(idle);
      tbl.push_back(idle);
      tbl.push_back(mk(4'b1111, '0, {5'd14, 5'd10, 5'd6, 5'd2}, '0, 4'b0001));
      tbl.push_back(mk(4'b1110, '0, {5'd14, 5'd10, 5'd6, 5'd2}, '0, 4'b0010));
      tbl.push_back(mk(4'b1100, '0, {5'd14, 5'd10, 5'd6, 5'd2}, '0, 4'b0100));
      tbl.push_back(mk(4'b1000, '0, {5'd14, 5'd10, 5'd6, 5'd2}, '0, 4'b1000));
      tbl.push_back(mk(4'b1111, '0, {5'd12, 5'd9, 5'd6, 5'd3}, '0, 4'b1111));
      tbl.push_back(idle);
      tbl.push_back(mk(4'b0110, 4'b0010, {5'd0, 5'd9, 5'd9, 5'd0},
                       {64'h0, 64'h0, 64'h1234, 64'h0}, 4'b0010));
      tbl.push_back(mk(4'b0100, '0, {5'd0, 5'd9, 5'd0, 5'd0}, '0, 4'b0100));
      tbl.push_back(idle);
      tbl.push_back(idle);
      tbl.push_back(mk(4'b1111, 4'b1010, {5'd8, 5'd1, 5'd4, 5'd7},
                       {64'hAAAA_0003, 64'h0, 64'hBBBB_0001, 64'h0}, 4'b0111));
      tbl.push_back(mk(4'b1001, 4'b1000, {5'd8, 5'd0, 5'd0, 5'd4},
                       {64'hAAAA_0003, 64'h0, 64'h0, 64'h0}, 4'b1000));
      tbl.push_back(mk(4'b0001, '0, {5'd0, 5'd0, 5'd0, 5'd4}, '0, 4'b0001));
      tbl.push_back(mk(4'b0100, '0, {5'd0, 5'd2, 5'd0, 5'd0}, '0, 4'b0100));
      tbl.push_back(mk(4'b0100, '0, {5'd0, 5'd2, 5'd0, 5'd0}, '0, 4'b0100));
      tbl.push_back(mk(4'b0010, '0, {5'd0, 5'd0, 5'd8, 5'd0}, '0, 4'b0010));
      tbl.push_back(idle);
      tbl.push_back(idle);

      do_reset();
      for (int k = 0; k < tbl.size(); k++) apply(tbl[k], $sformatf("v%0d", k));

      // Read in flight when reset arrives must vanish, and pointers must return to 0.
      do_reset();
      apply(mk(4'b0100, '0, {5'd0, 5'd1, 5'd0, 5'd0}, '0, 4'b0100), "rst_a");
      apply(idle, "rst_b");
      apply(idle, "rst_c");
      req_valid = 4'b0001;
      req_write = '0;
      req_reg   = {5'd0, 5'd0, 5'd0, 5'd1};
      req_wdata = '0;
      #1;
      check("rst_T.gnt", {252'b0, gnt}, 256'h1);
      @(posedge clk);
      #1;
      check("rst_T1.bank_read", {252'b0, bank_read}, 256'h2);
      rst_n = 1'b0;
      #1;
      check("rst_T1.gnt_low", {252'b0, gnt}, 256'h0);
      @(posedge clk);
      #1;
      check("rst_T2.rsp_valid", {252'b0, rsp_valid}, 256'h0);
      check("rst_T2.bank_read", {252'b0, bank_read}, 256'h0);
      check("rst_T2.bank_write", {252'b0, bank_write}, 256'h0);
      check("rst_T2.bank_target", {244'b0, bank_target}, 256'h0);
      check("rst_T2.bank_wdata", bank_wdata, 256'h0);
      check("rst_T2.conflict_cnt", {240'b0, conflict_cnt}, 256'h0);
      reset_model();
      rst_n = 1'b1;
      apply(mk(4'b0011, '0, {5'd0, 5'd0, 5'd5, 5'd1}, '0, 4'b0001), "rst_post");
      apply(idle, "rst_d");
      apply(idle, "rst_e");
      check("sb_drain", 256'(sb.size()), 256'h0);

      // Four requesters hammering bank 0 add 3 stalls per cycle until the counter pins.
      do_reset();
      req_valid = 4'b1111;
      req_write = '0;
      req_reg   = {5'd12, 5'd8, 5'd4, 5'd0};
      sat = 0;
      for (int n = 0; n < 21844; n++) begin
         @(posedge clk);
         sat = sat + 3;
      end
      #1;
      check("sat.near", {240'b0, conflict_cnt}, 256'(sat));
      @(posedge clk);
      #1;
      check("sat.limit", {240'b0, conflict_cnt}, 256'hFFFF);
      @(posedge clk);
      #1;
      check("sat.hold", {240'b0, conflict_cnt}, 256'hFFFF);
      repeat (4) @(posedge clk);
      #1;
      check("sat.hold_long", {240'b0, conflict_cnt}, 256'hFFFF);
      req_valid = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gpu_bank_arbiter.md
# gpu_bank_arbiter

Shares the four register-file banks of one warp among NUM_REQ requesters (operand collectors and the writeback port). Each cycle it grants at most one access per bank, chosen round-robin among the requesters targeting that bank. It drives the bank read/write/target/data strobes and routes read data back to the winning requester with a fixed latency. It sits between the warp issue logic and the `gpu_bank` instances inside `gpu_memory`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters.
- `NUM_BANKS`, 4: banks per warp.
- `REGS_PER_BANK`, 8: register entries per bank.
- `DATA_W`, 64: register width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_reg` in NUM_REQ*5: register number per requester; bank = `req_reg[1:0]`, entry = `req_reg[4:2]`.
- `req_wdata` in NUM_REQ*DATA_W: write data per requester.
- `gnt` out NUM_REQ: combinational grant; handshake completes when `req_valid[i] & gnt[i]`.
- `bank_read` out NUM_BANKS: registered read strobe per bank.
- `bank_write` out NUM_BANKS: registered write strobe per bank.
- `bank_target` out NUM_BANKS*3: registered entry index per bank.
- `bank_wdata` out NUM_BANKS*DATA_W: registered write data per bank.
- `bank_rdata` in NUM_BANKS*DATA_W: bank read data, valid the cycle after `bank_read`.
- `rsp_valid` out NUM_REQ: read response valid.
- `rsp_data` out NUM_REQ*DATA_W: read data per requester.
- `conflict_cnt` out 16: saturating count of stalled requests.

## Operation
- **Request hold:** a requester holds `req_valid`, `req_write`, `req_reg` and `req_wdata` stable until it is granted. Dropping a request before grant is allowed; the dropped request is not counted or served.
- **Per-bank arbitration:** each bank has a 2-bit round-robin pointer `ptr[b]`, reset to 0.
  - Candidates are requesters with `req_valid` whose bank field equals b.
  - The winner is the first candidate found scanning upward from `ptr[b]`, wrapping at NUM_REQ.
  - After a grant to requester i, `ptr[b]` becomes (i+1) mod NUM_REQ.
  - A bank with no candidates keeps its pointer.
- **Grant properties:** each requester targets exactly one bank, so each requester gets at most one grant per cycle. Up to NUM_BANKS grants occur per cycle when the requests hit distinct banks.
- **Bank command (cycle after grant, T+1):**
  - `bank_read[b]` = !write and `bank_write[b]` = write.
  - `bank_target[b]` = entry and `bank_wdata[b]` = the winner's wdata.
  - A bank with no grant has both strobes at 0. `bank_target` and `bank_wdata` hold their previous values.
- **Tag pipeline:** each bank carries a 2-stage tag pipeline (valid, requester id, is-read).
  - At T+2, when the tag is a valid read, `rsp_valid[id]` = 1 and `rsp_data[id]` = `bank_rdata[b]`.
  - Writes produce no response.
  - `rsp_data` for a requester with `rsp_valid` = 0 is don't-care.
- **Read-after-write:** a write granted at T is committed by the bank at the end of T+1. A read of the same register granted at T+1 or later returns the new value. Same-register accesses always target the same bank, so arbitration orders them by grant cycle.
- **Conflict counter:** each cycle, `conflict_cnt` += (valid requests) − (grants), saturating at 16'hFFFF.

## Timing
- `gnt` is combinational from `req_valid`, `req_reg` and `ptr`; there are no combinational paths from `bank_rdata` to `gnt`.
- Read latency is exactly 2 cycles from the grant cycle to `rsp_valid`, with no variable delay.
- Throughput is one access per bank per cycle, sustained.
- A single requester can be granted on consecutive cycles. With full contention, every requester on a bank is granted within NUM_REQ cycles (starvation bound).
- Reset (`rst_n` low at a rising edge):
  - `ptr` = 0 and `conflict_cnt` = 0.
  - `bank_read`, `bank_write` and `rsp_valid` = 0; `bank_target` = 0; `bank_wdata` = 0.
  - Tag pipelines are cleared; in-flight reads are dropped and never responded.
  - `gnt` = 0 while `rst_n` is low.
- First grants are possible in the first cycle with `rst_n` high.

## Test plan
- **Single read:** requester 0 reads reg 5 (bank 1, entry 1) at T.
  - Required: `gnt` = 4'b0001 at T; `bank_read` = 4'b0010 and `bank_target[1]` = 1 at T+1.
  - Bank returns 64'hDEAD at T+2 → `rsp_valid` = 4'b0001, `rsp_data[0]` = 64'hDEAD.
- **Full contention:** all 4 requesters hold reads to bank 2 from reset.
  - Required: grants go to 0, 1, 2, 3 on consecutive cycles, one grant per cycle.
  - `conflict_cnt` reads 3, 5, 6, 6 after each cycle.
- **Parallel, no conflict:** requesters 0–3 read banks 3, 2, 1, 0 at the same time.
  - Required: `gnt` = 4'b1111, `bank_read` = 4'b1111 next cycle, all 4 `rsp_valid` two cycles after the grant, `conflict_cnt` stays 0.
- **Read-after-write:** requester 1 writes 64'h1234 to reg 9 at T; requester 2 reads reg 9 from T.
  - Required: requester 1 granted at T; requester 2 granted at T+1.
  - `rsp_data[2]` = 64'h1234 at T+3.
- **Reset mid-flight:** read granted at T; `rst_n` low at T+1.
  - Required: no `rsp_valid` at T+2, all outputs at their reset values, `ptr` back to 0.
- **Saturation:** force `conflict_cnt` near its limit with sustained 4-way contention.
  - Required: the count holds at 16'hFFFF and does not wrap.
